generic_bus_burst_subordinate: RTL and testbench

- Address-decoded GenericBus subordinate with an internal burst engine.
- Sits between a managing `GenericBus_if` and one device.
- Decodes the window, generates per-beat device addresses for FIXED/INCR/WRAP bursts, and enforces a secure-only policy.
- Aborts stalled transfers with a busy-timeout error.

---
 rtl/generic_bus_pkg.sv | 24 ++
 rtl/generic_bus_if.sv | 31 +++
 rtl/generic_bus_burst_addr_gen.sv | 30 +++
 rtl/generic_bus_burst_subordinate.sv | 186 ++++++++++++++++++
 tb/tb_generic_bus_burst_subordinate.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/generic_bus_pkg.sv
// Shared GenericBus definitions: burst encodings, FSM states and the WRAP legality check.
package generic_bus_pkg;

  localparam int LEN_W   = 4;
  localparam int BEATS_W = LEN_W + 1;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_type_e;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // A WRAP burst needs a power-of-two beat count so the wrap boundary is aligned.
  function automatic logic WrapLegal(input logic [BEATS_W-1:0] beats);
    return (beats == BEATS_W'(2)) || (beats == BEATS_W'(4)) ||
           (beats == BEATS_W'(8)) || (beats == BEATS_W'(16));
  endfunction

endpackage

// File: rtl/generic_bus_if.sv
// GenericBus interface: one manager drives the request, one subordinate answers.
interface GenericBus_if #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
) ();

  logic [AddrWidth-1:0]                addr;
  logic                                wEn;
  logic                                rEn;
  logic [DataWidth-1:0]                wData;
  logic [DataWidth/8-1:0]              wStrb;
  logic [DataWidth-1:0]                rData;
  logic                                busy;
  logic                                error;
  logic                                nonSec;
  logic [2:0]                          prot;
  logic                                isBurst;
  logic [generic_bus_pkg::LEN_W-1:0]   burstLen;
  generic_bus_pkg::burst_type_e        burstType;

  modport mgr (
    output addr, wEn, rEn, wData, wStrb, nonSec, prot, isBurst, burstLen, burstType,
    input  rData, busy, error
  );

  modport sub (
    input  addr, wEn, rEn, wData, wStrb, nonSec, prot, isBurst, burstLen, burstType,
    output rData, busy, error
  );

endinterface

// File: rtl/generic_bus_burst_addr_gen.sv
// Next-beat offset for FIXED / INCR / WRAP bursts; purely combinational.
module generic_bus_burst_addr_gen
  import generic_bus_pkg::*;
#(
  parameter int AddrWidth = 32
) (
  input  logic [AddrWidth-1:0] offset,
  input  burst_type_e          btype,
  input  logic [BEATS_W-1:0]   beats,
  input  logic [AddrWidth-1:0] bytes,
  output logic [AddrWidth-1:0] next_offset
);

  logic [AddrWidth-1:0] incr;
  logic [AddrWidth-1:0] wrap_mask;

  // Step the offset by one beat; WRAP keeps the upper bits of the aligned window.
  always_comb begin
    incr        = offset + bytes;
    wrap_mask   = (AddrWidth'(beats) * bytes) - AddrWidth'(1);
    next_offset = offset;
    case (btype)
      FIXED:   next_offset = offset;
      INCR:    next_offset = incr;
      WRAP:    next_offset = (offset & ~wrap_mask) | (incr & wrap_mask);
      default: next_offset = offset;
    endcase
  end

endmodule

// File: rtl/generic_bus_burst_subordinate.sv
// Address-decoded GenericBus subordinate: window decode, secure policy,
// burst address generation and busy-timeout abort toward a single device.
module generic_bus_burst_subordinate
  import generic_bus_pkg::*;
#(
  parameter int                   AddrWidth     = 32,
  parameter int                   DataWidth     = 32,
  parameter logic [AddrWidth-1:0] BaseAddr      = '0,
  parameter logic [AddrWidth-1:0] AddrMask      = '1,
  parameter bit                   SecureOnly    = 1'b0,
  parameter int                   TimeoutCycles = 16
) (
  input logic       clk,
  input logic       nReset,
  GenericBus_if.sub bus,
  GenericBus_if.mgr device
);

  localparam logic [AddrWidth-1:0] BYTES    = AddrWidth'(DataWidth / 8);
  localparam int                   CNT_W    = 16;
  localparam logic [CNT_W-1:0]     TO_LIMIT = CNT_W'(TimeoutCycles);

  state_e               state_q, state_d;
  logic [LEN_W-1:0]     rem_q, rem_d;
  logic [LEN_W-1:0]     len_q, len_d;
  burst_type_e          btype_q, btype_d;
  logic [AddrWidth-1:0] offset_q, offset_d;
  logic [CNT_W-1:0]     busy_cnt_q, busy_cnt_d;

  logic                 any_en;
  logic                 sel;
  logic                 refuse;
  logic [BEATS_W-1:0]   req_beats;
  logic                 wrap_bad;
  logic [AddrWidth-1:0] start_offset;

  logic [AddrWidth-1:0] gen_offset;
  burst_type_e          gen_type;
  logic [BEATS_W-1:0]   gen_beats;
  logic [AddrWidth-1:0] next_offset;

  logic                 en_raw;
  logic                 en;
  logic                 active;
  logic                 timeout_hit;
  logic                 complete;
  logic                 int_err;
  logic [AddrWidth-1:0] dev_addr;

  // Window decode, security refusal and WRAP legality of the incoming request.
  always_comb begin
    any_en       = bus.wEn | bus.rEn;
    sel          = ((bus.addr & AddrMask) == BaseAddr) && any_en;
    refuse       = SecureOnly && bus.nonSec;
    req_beats    = BEATS_W'(bus.burstLen) + BEATS_W'(1);
    wrap_bad     = bus.isBurst && (bus.burstType == WRAP) && !WrapLegal(req_beats);
    start_offset = bus.addr - BaseAddr;
  end

  // The generator works from the live request on the first beat, from latched state afterwards.
  always_comb begin
    if (state_q == BURST) begin
      gen_offset = offset_q;
      gen_type   = btype_q;
      gen_beats  = BEATS_W'(len_q) + BEATS_W'(1);
    end else begin
      gen_offset = start_offset;
      gen_type   = bus.burstType;
      gen_beats  = req_beats;
    end
  end

  generic_bus_burst_addr_gen #(
    .AddrWidth (AddrWidth)
  ) u_addr_gen (
    .offset      (gen_offset),
    .btype       (gen_type),
    .beats       (gen_beats),
    .bytes       (BYTES),
    .next_offset (next_offset)
  );

  // FSM next-state, counters and beat qualification; timeout beats abort beats completion.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    len_d      = len_q;
    btype_d    = btype_q;
    offset_d   = offset_q;
    busy_cnt_d = '0;
    en_raw     = 1'b0;
    int_err    = 1'b0;
    dev_addr   = '0;

    case (state_q)
      IDLE: begin
        if (sel) begin
          if (refuse || wrap_bad) begin
            int_err = 1'b1;
          end else begin
            en_raw   = 1'b1;
            dev_addr = start_offset;
          end
        end
      end
      BURST: begin
        en_raw   = any_en;
        dev_addr = offset_q;
      end
      default: state_d = IDLE;
    endcase

    timeout_hit = (TimeoutCycles != 0) && en_raw && device.busy &&
                  (busy_cnt_q == TO_LIMIT - CNT_W'(1));
    en          = en_raw && !timeout_hit;
    complete    = en && !device.busy;

    if (en && device.busy) begin
      busy_cnt_d = busy_cnt_q + CNT_W'(1);
    end

    if (timeout_hit) begin
      int_err = 1'b1;
      state_d = IDLE;
      rem_d   = '0;
    end else if ((state_q == BURST) && !any_en) begin
      state_d = IDLE;
      rem_d   = '0;
    end else if (complete) begin
      if (state_q == IDLE) begin
        if (bus.isBurst && (bus.burstLen != '0)) begin
          state_d  = BURST;
          rem_d    = bus.burstLen;
          len_d    = bus.burstLen;
          btype_d  = bus.burstType;
          offset_d = next_offset;
        end
      end else begin
        offset_d = next_offset;
        rem_d    = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) begin
          state_d = IDLE;
        end
      end
    end
  end

  // State, latched burst context and busy counter.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      len_q      <= '0;
      btype_q    <= FIXED;
      offset_q   <= '0;
      busy_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      len_q      <= len_d;
      btype_q    <= btype_d;
      offset_q   <= offset_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Reset gates the outputs directly so enables fall the instant nReset asserts.
  assign active = en && nReset;

  assign device.wEn       = active && bus.wEn;
  assign device.rEn       = active && bus.rEn;
  assign device.addr      = active ? dev_addr : '0;
  assign device.wData     = bus.wData;
  assign device.wStrb     = bus.wStrb;
  assign device.nonSec    = bus.nonSec;
  assign device.prot      = bus.prot;
  // The device only ever sees single beats; burst sequencing happens here.
  assign device.isBurst   = 1'b0;
  assign device.burstLen  = '0;
  assign device.burstType = FIXED;

  assign bus.rData = active ? device.rData : '0;
  assign bus.busy  = active && device.busy;
  assign bus.error = nReset && (int_err || (active && device.error));

endmodule

// File: tb/tb_generic_bus_burst_subordinate.sv
// Directed bench for generic_bus_burst_subordinate (base 0x1000, mask 0xF000, 32-bit data).
module tb_generic_bus_burst_subordinate;
  import generic_bus_pkg::*;

  logic clk;
  logic nReset;
  int   errors;
  int   checks;

  GenericBus_if #(.AddrWidth(16), .DataWidth(32)) bus_if ();
  GenericBus_if #(.AddrWidth(16), .DataWidth(32)) dev_if ();

  generic_bus_burst_subordinate #(
    .AddrWidth     (16),
    .DataWidth     (32),
    .BaseAddr      (16'h1000),
    .AddrMask      (16'hF000),
    .SecureOnly    (1'b1),
    .TimeoutCycles (4)
  ) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus_if),
    .device (dev_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic bus_idle();
    bus_if.addr      = '0;
    bus_if.wEn       = 1'b0;
    bus_if.rEn       = 1'b0;
    bus_if.wData     = '0;
    bus_if.wStrb     = '0;
    bus_if.nonSec    = 1'b0;
    bus_if.prot      = '0;
    bus_if.isBurst   = 1'b0;
    bus_if.burstLen  = '0;
    bus_if.burstType = FIXED;
    dev_if.rData     = '0;
    dev_if.busy      = 1'b0;
    dev_if.error     = 1'b0;
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    bus_idle();
    bus_if.addr = 16'h1004;
    bus_if.rEn  = 1'b1;
    #1;
    checks++; if (dev_if.rEn !== 1'b0) begin errors++; $display("FAIL reset_ren: got %b want 0", dev_if.rEn); end
    checks++; if (dev_if.addr !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h want 0000", dev_if.addr); end
    checks++; if (bus_if.error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", bus_if.error); end
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus_if.busy); end
    @(negedge clk);
    @(negedge clk);
    nReset = 1'b1;
    bus_idle();
    #1;
    checks++; if (dev_if.wEn !== 1'b0) begin errors++; $display("FAIL reset_idle_wen: got %b want 0", dev_if.wEn); end
  endtask

  task automatic test_single_read();
    @(negedge clk);
    bus_if.addr  = 16'h1004;
    bus_if.rEn   = 1'b1;
    dev_if.rData = 32'hDEADBEEF;
    #1;
    checks++; if (dev_if.addr !== 16'h0004) begin errors++; $display("FAIL single_addr: got %h want 0004", dev_if.addr); end
    checks++; if (dev_if.rEn !== 1'b1) begin errors++; $display("FAIL single_ren: got %b want 1", dev_if.rEn); end
    checks++; if (bus_if.rData !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata: got %h want deadbeef", bus_if.rData); end
    checks++; if (bus_if.error !== 1'b0) begin errors++; $display("FAIL single_error: got %b want 0", bus_if.error); end
    @(negedge clk);
    bus_if.rEn = 1'b0;
    #1;
    checks++; if (dev_if.rEn !== 1'b0) begin errors++; $display("FAIL single_ren_drop: got %b want 0", dev_if.rEn); end
    checks++; if (bus_if.rData !== 32'h0) begin errors++; $display("FAIL single_rdata_idle: got %h want 0", bus_if.rData); end
    @(negedge clk);
    bus_if.addr = 16'h2004;
    bus_if.rEn  = 1'b1;
    #1;
    checks++; if (dev_if.rEn !== 1'b0) begin errors++; $display("FAIL unselected_ren: got %b want 0", dev_if.rEn); end
    checks++; if (bus_if.error !== 1'b0) begin errors++; $display("FAIL unselected_error: got %b want 0", bus_if.error); end
    bus_idle();
  endtask

  task automatic test_burst(input string name, input logic [15:0] start, input burst_type_e bt,
                            input logic wr, input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] exp_a [4];
    exp_a[0] = e0; exp_a[1] = e1; exp_a[2] = e2; exp_a[3] = e3;
    @(negedge clk);
    bus_if.addr      = start;
    bus_if.wEn       = wr;
    bus_if.rEn       = !wr;
    bus_if.isBurst   = 1'b1;
    bus_if.burstLen  = 4'd3;
    bus_if.burstType = bt;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (dev_if.addr !== exp_a[i]) begin errors++; $display("FAIL %s_addr%0d: got %h want %h", name, i, dev_if.addr, exp_a[i]); end
      checks++; if ((wr ? dev_if.wEn : dev_if.rEn) !== 1'b1) begin errors++; $display("FAIL %s_en%0d: got 0 want 1", name, i); end
      @(negedge clk);
      bus_if.addr = 16'h1FF0;
    end
    bus_if.addr    = 16'h1040;
    bus_if.isBurst = 1'b0;
    #1;
    checks++; if (dev_if.addr !== 16'h0040) begin errors++; $display("FAIL %s_back_idle: got %h want 0040", name, dev_if.addr); end
    @(negedge clk);
    bus_idle();
  endtask

  task automatic test_wrap_illegal();
    @(negedge clk);
    bus_if.addr      = 16'h1018;
    bus_if.rEn       = 1'b1;
    bus_if.isBurst   = 1'b1;
    bus_if.burstLen  = 4'd2;
    bus_if.burstType = WRAP;
    #1;
    checks++; if (bus_if.error !== 1'b1) begin errors++; $display("FAIL wrap3_error: got %b want 1", bus_if.error); end
    checks++; if (dev_if.rEn !== 1'b0) begin errors++; $display("FAIL wrap3_ren: got %b want 0", dev_if.rEn); end
    @(negedge clk);
    bus_idle();
    bus_if.addr = 16'h1008;
    bus_if.rEn  = 1'b1;
    #1;
    checks++; if (dev_if.addr !== 16'h0008) begin errors++; $display("FAIL wrap3_still_idle: got %h want 0008", dev_if.addr); end
    @(negedge clk);
    bus_idle();
  endtask

  task automatic test_abort();
    @(negedge clk);
    bus_if.addr      = 16'h1000;
    bus_if.rEn       = 1'b1;
    bus_if.isBurst   = 1'b1;
    bus_if.burstLen  = 4'd3;
    bus_if.burstType = INCR;
    @(negedge clk);
    #1;
    checks++; if (dev_if.addr !== 16'h0004) begin errors++; $display("FAIL abort_beat1: got %h want 0004", dev_if.addr); end
    @(negedge clk);
    bus_if.rEn = 1'b0;
    #1;
    checks++; if (dev_if.rEn !== 1'b0) begin errors++; $display("FAIL abort_ren: got %b want 0", dev_if.rEn); end
    checks++; if (bus_if.error !== 1'b0) begin errors++; $display("FAIL abort_error: got %b want 0", bus_if.error); end
    @(negedge clk);
    bus_if.addr    = 16'h1030;
    bus_if.rEn     = 1'b1;
    bus_if.isBurst = 1'b0;
    #1;
    checks++; if (dev_if.addr !== 16'h0030) begin errors++; $display("FAIL abort_idle_addr: got %h want 0030", dev_if.addr); end
    @(negedge clk);
    bus_idle();
  endtask

  task automatic test_timeout();
    @(negedge clk);
    bus_if.addr = 16'h1000;
    bus_if.rEn  = 1'b1;
    dev_if.busy = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      #1;
      checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_c%0d: got %b want 1", c, bus_if.busy); end
      checks++; if (bus_if.error !== 1'b0) begin errors++; $display("FAIL timeout_noerr_c%0d: got %b want 0", c, bus_if.error); end
      @(negedge clk);
    end
    #1;
    checks++; if (bus_if.error !== 1'b1) begin errors++; $display("FAIL timeout_error: got %b want 1", bus_if.error); end
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL timeout_busy_drop: got %b want 0", bus_if.busy); end
    checks++; if (dev_if.rEn !== 1'b0) begin errors++; $display("FAIL timeout_ren: got %b want 0", dev_if.rEn); end
    @(negedge clk);
    bus_idle();
    @(negedge clk);
    bus_if.addr = 16'h1000;
    bus_if.rEn  = 1'b1;
    dev_if.busy = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      #1;
      checks++; if (bus_if.error !== 1'b0) begin errors++; $display("FAIL timeout_cleared_c%0d: got %b want 0", c, bus_if.error); end
      @(negedge clk);
    end
    dev_if.busy = 1'b0;
    #1;
    checks++; if (dev_if.rEn !== 1'b1) begin errors++; $display("FAIL timeout_late_done: got %b want 1", dev_if.rEn); end
    @(negedge clk);
    bus_idle();
  endtask

  task automatic test_secure();
    @(negedge clk);
    bus_if.addr   = 16'h1010;
    bus_if.wEn    = 1'b1;
    bus_if.wData  = 32'hA5A5_0F0F;
    bus_if.wStrb  = 4'hF;
    bus_if.nonSec = 1'b1;
    #1;
    checks++; if (bus_if.error !== 1'b1) begin errors++; $display("FAIL secure_refuse_error: got %b want 1", bus_if.error); end
    checks++; if (dev_if.wEn !== 1'b0) begin errors++; $display("FAIL secure_refuse_wen: got %b want 0", dev_if.wEn); end
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL secure_refuse_busy: got %b want 0", bus_if.busy); end
    @(negedge clk);
    bus_if.nonSec = 1'b0;
    #1;
    checks++; if (dev_if.wEn !== 1'b1) begin errors++; $display("FAIL secure_ok_wen: got %b want 1", dev_if.wEn); end
    checks++; if (dev_if.addr !== 16'h0010) begin errors++; $display("FAIL secure_ok_addr: got %h want 0010", dev_if.addr); end
    checks++; if (dev_if.wData !== 32'hA5A5_0F0F) begin errors++; $display("FAIL secure_ok_wdata: got %h want a5a50f0f", dev_if.wData); end
    checks++; if (bus_if.error !== 1'b0) begin errors++; $display("FAIL secure_ok_error: got %b want 0", bus_if.error); end
    @(negedge clk);
    dev_if.error = 1'b1;
    #1;
    checks++; if (bus_if.error !== 1'b1) begin errors++; $display("FAIL device_error_pass: got %b want 1", bus_if.error); end
    @(negedge clk);
    bus_idle();
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    bus_if.addr      = 16'h1000;
    bus_if.rEn       = 1'b1;
    bus_if.isBurst   = 1'b1;
    bus_if.burstLen  = 4'd3;
    bus_if.burstType = INCR;
    @(negedge clk);
    #1;
    checks++; if (dev_if.addr !== 16'h0004) begin errors++; $display("FAIL rst_mid_beat2: got %h want 0004", dev_if.addr); end
    #1;
    nReset = 1'b0;
    #1;
    checks++; if (dev_if.rEn !== 1'b0) begin errors++; $display("FAIL rst_mid_ren: got %b want 0", dev_if.rEn); end
    checks++; if (dev_if.addr !== 16'h0000) begin errors++; $display("FAIL rst_mid_addr: got %h want 0000", dev_if.addr); end
    @(negedge clk);
    @(negedge clk);
    nReset          = 1'b1;
    bus_if.addr     = 16'h1020;
    bus_if.burstLen = 4'd1;
    #1;
    checks++; if (dev_if.addr !== 16'h0020) begin errors++; $display("FAIL rst_new_beat0: got %h want 0020", dev_if.addr); end
    @(negedge clk);
    #1;
    checks++; if (dev_if.addr !== 16'h0024) begin errors++; $display("FAIL rst_new_beat1: got %h want 0024", dev_if.addr); end
    @(negedge clk);
    bus_idle();
  endtask

  initial begin
    clk    = 1'b0;
    errors = 0;
    checks = 0;
    test_reset();
    test_single_read();
    test_burst("incr", 16'h1008, INCR, 1'b0, 16'h0008, 16'h000C, 16'h0010, 16'h0014);
    test_burst("wrap", 16'h1018, WRAP, 1'b0, 16'h0018, 16'h001C, 16'h0010, 16'h0014);
    test_burst("fixed_wr", 16'h100C, FIXED, 1'b1, 16'h000C, 16'h000C, 16'h000C, 16'h000C);
    test_wrap_illegal();
    test_abort();
    test_timeout();
    test_secure();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
